// File: rtl/qk_core_pkg.sv
// Shared definitions for the Q.K core sequencer: instruction word layout and FSM states.
package qk_core_pkg;

    localparam int INST_W        = 17;
    localparam int ADDR_W        = 4;

    localparam int OFIFO_RD      = 16;
    localparam int QKMEM_ADD_LSB = 12;
    localparam int PMEM_ADD_LSB  = 8;
    localparam int EXECUTE       = 7;
    localparam int LOAD          = 6;
    localparam int QMEM_RD       = 5;
    localparam int QMEM_WR       = 4;
    localparam int KMEM_RD       = 3;
    localparam int KMEM_WR       = 2;
    localparam int PMEM_RD       = 1;
    localparam int PMEM_WR       = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_QWR,
        S_KWR,
        S_KLOAD,
        S_EXEC,
        S_DRAIN,
        S_MOVE,
        S_RDOUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/qk_core_seq.sv
// Instruction sequencer for one Q.K attention-score pass; every output is registered,
// so inst reflects the decision made at the previous clock edge.
module qk_core_seq
    import qk_core_pkg::*;
#(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int cnt_w       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [cnt_w-1:0] TC_LAST  = cnt_w'(total_cycle - 1);
    localparam logic [cnt_w-1:0] TC_END   = cnt_w'(total_cycle);
    localparam logic [cnt_w-1:0] COL_LAST = cnt_w'(col - 1);
    localparam logic [cnt_w-1:0] COL_RD   = cnt_w'(col);
    localparam logic [cnt_w-1:0] COL_END  = cnt_w'(col + 1);

    state_t             state, state_next;
    logic [cnt_w-1:0]   cnt, cnt_next, cnt_dec;
    logic [INST_W-1:0]  inst_next;

    assign cnt_dec = cnt - cnt_w'(1);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        inst_next  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_QWR;
                    cnt_next   = '0;
                end
            end
            S_QWR: begin
                if (in_valid) begin
                    inst_next[QMEM_WR] = 1'b1;
                    inst_next[QKMEM_ADD_LSB +: ADDR_W] = cnt[ADDR_W-1:0];
                    if (cnt == TC_LAST) begin
                        state_next = S_KWR;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + cnt_w'(1);
                    end
                end
            end
            S_KWR: begin
                if (in_valid) begin
                    inst_next[KMEM_WR] = 1'b1;
                    inst_next[QKMEM_ADD_LSB +: ADDR_W] = cnt[ADDR_W-1:0];
                    if (cnt == COL_LAST) begin
                        state_next = S_KLOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + cnt_w'(1);
                    end
                end
            end
            S_KLOAD: begin
                // First and last cycles keep load high without reading, framing the column shift.
                inst_next[LOAD] = 1'b1;
                if (cnt != '0 && cnt <= COL_RD) begin
                    inst_next[KMEM_RD] = 1'b1;
                    inst_next[QKMEM_ADD_LSB +: ADDR_W] = cnt_dec[ADDR_W-1:0];
                end
                if (cnt == COL_END) begin
                    state_next = S_EXEC;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + cnt_w'(1);
                end
            end
            S_EXEC: begin
                inst_next[EXECUTE] = 1'b1;
                inst_next[QMEM_RD] = 1'b1;
                inst_next[QKMEM_ADD_LSB +: ADDR_W] = cnt[ADDR_W-1:0];
                if (cnt == TC_LAST) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + cnt_w'(1);
                end
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    state_next = S_MOVE;
                end
            end
            S_MOVE: begin
                if (ofifo_valid) begin
                    inst_next[OFIFO_RD] = 1'b1;
                    inst_next[PMEM_WR]  = 1'b1;
                    inst_next[PMEM_ADD_LSB +: ADDR_W] = cnt[ADDR_W-1:0];
                    if (cnt == TC_LAST) begin
                        state_next = S_RDOUT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + cnt_w'(1);
                    end
                end
            end
            S_RDOUT: begin
                // One extra idle count lets the final read's data land in the DONE cycle.
                if (cnt != TC_END) begin
                    inst_next[PMEM_RD] = 1'b1;
                    inst_next[PMEM_ADD_LSB +: ADDR_W] = cnt[ADDR_W-1:0];
                    cnt_next = cnt + cnt_w'(1);
                end else begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            inst      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            inst      <= inst_next;
            in_ready  <= (state_next == S_QWR) || (state_next == S_KWR);
            out_valid <= inst[PMEM_RD];
            out_addr  <= inst[PMEM_ADD_LSB +: ADDR_W];
            busy      <= (state_next != S_IDLE);
            done      <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_qk_core_seq.sv
// Directed bench for qk_core_seq with a behavioural Q.K core model and expectation queues.
module tb_qk_core_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        ofifo_valid;
    logic [16:0] inst;
    logic        out_valid;
    logic [3:0]  out_addr;
    logic        busy;
    logic        done;

    qk_core_seq #(.total_cycle(8), .col(8), .cnt_w(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // host data: 4 elements of 4 bits per row
    logic [15:0]  q_data [8];
    logic [15:0]  k_data [8];
    // core model
    logic [15:0]  qmem [16];
    logic [15:0]  kmem [16];
    logic [15:0]  col_k [8];
    logic [127:0] pmem [16];
    logic [127:0] ofifo [$];
    logic [127:0] core_out;
    int           load_idx;
    // expectation queues
    int exp_qwr [$];
    int exp_kwr [$];
    int exp_krd [$];
    int exp_exec [$];
    int exp_pwr [$];
    int exp_out [$];
    int n_acc, n_load, load_runs, n_krd, n_exec, n_pwr, n_out, n_done;
    logic prev_load, prev_ofv, pass_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] dot_row(input logic [15:0] qv, input logic [15:0] kv [8]);
        logic [127:0] r;
        int s;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            s = 0;
            for (int e = 0; e < 4; e++)
                s = s + int'(qv[e*4 +: 4]) * int'(kv[j][e*4 +: 4]);
            r[j*16 +: 16] = 16'(s);
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_row(input int a);
        return dot_row(q_data[a], k_data);
    endfunction

    task automatic prep_pass();
        exp_qwr.delete(); exp_kwr.delete(); exp_krd.delete();
        exp_exec.delete(); exp_pwr.delete(); exp_out.delete(); ofifo.delete();
        for (int i = 0; i < 8; i++) begin
            q_data[i] = 16'($urandom);
            k_data[i] = 16'($urandom);
            col_k[i]  = '0;
            exp_krd.push_back(i);
            exp_exec.push_back(i);
            exp_pwr.push_back(i);
            exp_out.push_back(i);
        end
        for (int i = 0; i < 16; i++) begin
            qmem[i] = '0; kmem[i] = '0; pmem[i] = '0;
        end
        core_out = '0; load_idx = 0;
        n_acc = 0; n_load = 0; load_runs = 0; n_krd = 0; n_exec = 0;
        n_pwr = 0; n_out = 0; n_done = 0;
        prev_load = 1'b0; prev_ofv = 1'b0; pass_done = 1'b0;
    endtask

    // called at each falling edge: observe DUT outputs, update the core model
    task automatic monitor_cycle();
        logic [3:0] qa, pa;
        int idx;
        qa = inst[15:12];
        pa = inst[11:8];
        if (out_valid) begin
            n_out++;
            chk("out_pending", 32'(exp_out.size() != 0), 32'd1);
            if (exp_out.size() != 0) begin
                idx = exp_out.pop_front();
                chk("out_addr", 32'(out_addr), 32'(idx));
                chk_row("out_data", core_out, ref_row(idx));
            end
        end
        core_out = inst[1] ? pmem[pa] : '0;
        if (inst[4]) begin
            chk("qwr_pending", 32'(exp_qwr.size() != 0), 32'd1);
            if (exp_qwr.size() != 0) begin
                idx = exp_qwr.pop_front();
                chk("qwr_addr", 32'(qa), 32'(idx));
                qmem[qa] = q_data[idx];
            end
        end
        if (inst[2]) begin
            chk("kwr_pending", 32'(exp_kwr.size() != 0), 32'd1);
            if (exp_kwr.size() != 0) begin
                idx = exp_kwr.pop_front();
                chk("kwr_addr", 32'(qa), 32'(idx));
                kmem[qa] = k_data[idx];
            end
        end
        if (inst[6]) begin
            n_load++;
            if (!prev_load) load_runs++;
        end
        if (inst[3]) begin
            n_krd++;
            chk("krd_with_load", 32'(inst[6]), 32'd1);
            if (exp_krd.size() != 0) begin
                idx = exp_krd.pop_front();
                chk("krd_addr", 32'(qa), 32'(idx));
            end
            if (load_idx < 8) col_k[load_idx] = kmem[qa];
            load_idx++;
        end
        if (inst[7]) begin
            n_exec++;
            chk("exec_qmem_rd", 32'(inst[5]), 32'd1);
            if (exp_exec.size() != 0) begin
                idx = exp_exec.pop_front();
                chk("exec_addr", 32'(qa), 32'(idx));
            end
            ofifo.push_back(dot_row(qmem[qa], col_k));
        end
        if (inst[16]) begin
            n_pwr++;
            chk("ofifo_rd_when_valid", 32'(prev_ofv), 32'd1);
            chk("ofifo_rd_pmem_wr", 32'(inst[0]), 32'd1);
            if (exp_pwr.size() != 0) begin
                idx = exp_pwr.pop_front();
                chk("pmem_wr_addr", 32'(pa), 32'(idx));
            end
            pmem[pa] = (ofifo.size() != 0) ? ofifo.pop_front() : '0;
        end
        if (done) begin
            n_done++;
            pass_done = 1'b1;
            chk("done_busy", 32'(busy), 32'd1);
        end
        if (in_ready && in_valid) begin
            if (n_acc < 8) exp_qwr.push_back(n_acc);
            else           exp_kwr.push_back(n_acc - 8);
            n_acc++;
        end
        prev_ofv  = ofifo_valid;
        prev_load = inst[6];
    endtask

    task automatic run_pass(input int iv_mode, input int fifo_mode,
                            input bit start_exec, input bit rst_exec3);
        int cyc, drain_cyc;
        bit aborted;
        prep_pass();
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; ofifo_valid = 1'b0;
        @(negedge clk); monitor_cycle();
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; drain_cyc = 0; aborted = 1'b0;
        while (!pass_done && !aborted && cyc < 400) begin
            in_valid = (iv_mode == 1 && n_acc < 8) ? (cyc % 2 == 0) : 1'b1;
            if (fifo_mode == 0) begin
                ofifo_valid = 1'b1;
            end else if (n_exec < 8) begin
                ofifo_valid = 1'b0;
            end else begin
                ofifo_valid = (drain_cyc >= 5) && ((drain_cyc - 5) % 2 == 0);
                drain_cyc++;
            end
            start = start_exec && (n_exec == 3);
            @(negedge clk); monitor_cycle();
            if (rst_exec3 && n_exec >= 3) begin
                reset = 1'b0;
                #1;
                chk("abort_inst", 32'(inst), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_in_ready", 32'(in_ready), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                repeat (2) @(posedge clk);
                #1;
                start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0;
                reset = 1'b1;
                aborted = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0;
        if (aborted) begin
            repeat (2) begin
                @(negedge clk);
                chk("post_abort_busy", 32'(busy), 32'd0);
                chk("post_abort_inst", 32'(inst), 32'd0);
            end
            chk("abort_no_done", 32'(n_done), 32'd0);
        end else begin
            chk("pass_complete", 32'(pass_done), 32'd1);
            @(negedge clk); monitor_cycle();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("done_pulse_width", 32'(done), 32'd0);
            chk("idle_inst", 32'(inst), 32'd0);
            chk("accepted_rows", 32'(n_acc), 32'd16);
            chk("qwr_all_written", 32'(exp_qwr.size()), 32'd0);
            chk("kwr_all_written", 32'(exp_kwr.size()), 32'd0);
            chk("load_cycles", 32'(n_load), 32'd10);
            chk("load_runs", 32'(load_runs), 32'd1);
            chk("kmem_rd_cycles", 32'(n_krd), 32'd8);
            chk("exec_cycles", 32'(n_exec), 32'd8);
            chk("pmem_wr_cycles", 32'(n_pwr), 32'd8);
            chk("out_valid_cycles", 32'(n_out), 32'd8);
            chk("done_count", 32'(n_done), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; in_valid = 1'b0; ofifo_valid = 1'b0;
        prep_pass();
        repeat (3) begin
            @(negedge clk);
            chk("rst_inst", 32'(inst), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rst_stays_idle", 32'(busy), 32'd0);
        $display("step: full pass, no back-pressure");
        run_pass(0, 0, 1'b0, 1'b0);
        $display("step: in_valid toggling during QWR");
        run_pass(1, 0, 1'b0, 1'b0);
        $display("step: ofifo_valid gaps in DRAIN/MOVE");
        run_pass(0, 1, 1'b0, 1'b0);
        $display("step: start pulse during EXEC");
        run_pass(0, 0, 1'b1, 1'b0);
        $display("step: reset at EXEC cycle 3");
        run_pass(0, 0, 1'b0, 1'b1);
        $display("step: clean pass after reset");
        run_pass(0, 0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
